// File: rtl/instr_mem_prog.sv
// rtl/instr_mem_prog.sv - reprogrammable instruction store with registered read port and valid/ready load port
module instr_mem_prog #(
   parameter int INSTR_W = 3,
   parameter int DEPTH   = 8,
   parameter int ADDR_W  = $clog2(DEPTH)
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_load_start,
   input  logic               i_load_valid,
   input  logic [INSTR_W-1:0] i_load_data,
   output logic               o_load_ready,
   output logic               o_load_done,
   input  logic               i_rd_en,
   input  logic [ADDR_W-1:0]  i_pc,
   output logic [INSTR_W-1:0] o_instr,
   output logic               o_instr_valid,
   output logic               o_pc_err,
   output logic               o_busy
);

   typedef enum logic {RUN, LOAD} state_t;

   localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(DEPTH - 1);
   localparam logic [ADDR_W:0]   DEPTH_V = (ADDR_W + 1)'(DEPTH);

   state_t              state, next_state;
   logic [ADDR_W-1:0]   ptr, next_ptr, wr_addr;
   logic                wr_en, done_d, rd_accept, pc_oob;
   logic [INSTR_W-1:0]  mem [DEPTH];

   // Built-in program image; entries past the original eight come up as zero.
   function automatic logic [INSTR_W-1:0] default_word(input int idx);
      logic [2:0] w;
      case (idx)
         1:       w = 3'b111;
         2:       w = 3'b001;
         3:       w = 3'b010;
         4:       w = 3'b001;
         5:       w = 3'b011;
         6:       w = 3'b100;
         7:       w = 3'b110;
         default: w = 3'b000;
      endcase
      return INSTR_W'(w);
   endfunction

   assign pc_oob       = ({1'b0, i_pc} >= DEPTH_V);
   assign o_busy       = (state == LOAD);
   assign o_load_ready = (state == LOAD);

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) state <= RUN;
      else       state <= next_state;
   end

   always_comb begin
      next_state = state;
      next_ptr   = ptr;
      wr_en      = 1'b0;
      wr_addr    = ptr;
      done_d     = 1'b0;
      rd_accept  = 1'b0;
      case (state)
         RUN: begin
            if (i_load_start) begin
               next_state = LOAD;
               next_ptr   = '0;
            end else if (i_rd_en) begin
               rd_accept = 1'b1;
            end
         end
         LOAD: begin
            // The final beat wins over a simultaneous restart.
            if (i_load_valid && ptr == LAST) begin
               wr_en      = 1'b1;
               next_ptr   = '0;
               done_d     = 1'b1;
               next_state = RUN;
            end else if (i_load_start) begin
               next_ptr = '0;
               if (i_load_valid) begin
                  wr_en    = 1'b1;
                  wr_addr  = '0;
                  next_ptr = ADDR_W'(1);
               end
            end else if (i_load_valid) begin
               wr_en    = 1'b1;
               next_ptr = ptr + ADDR_W'(1);
            end
         end
         default: next_state = RUN;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         ptr           <= '0;
         o_load_done   <= 1'b0;
         o_instr       <= '0;
         o_instr_valid <= 1'b0;
         o_pc_err      <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= default_word(i);
      end else begin
         ptr           <= next_ptr;
         o_load_done   <= done_d;
         o_instr_valid <= rd_accept;
         o_pc_err      <= rd_accept && pc_oob;
         if (wr_en) mem[wr_addr] <= i_load_data;
         if (rd_accept) o_instr <= pc_oob ? '0 : mem[i_pc];
      end
   end

endmodule

// File: tb/tb_instr_mem_prog.sv
// tb/tb_instr_mem_prog.sv - bench for instr_mem_prog: 8x3 and 6x4 instances driven in lockstep against a model
module tb_instr_mem_prog;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       start = 1'b0, lv = 1'b0, rd = 1'b0;
   logic [3:0] ld_data = '0;
   logic [2:0] pc = '0;

   logic       ready8, done8, ival8, err8, busy8;
   logic [2:0] instr8;
   logic       ready6, done6, ival6, err6, busy6;
   logic [3:0] instr6;

   int errors = 0;
   int checks = 0;

   instr_mem_prog dut8 (
      .i_clk(clk), .i_rst(rst), .i_load_start(start), .i_load_valid(lv),
      .i_load_data(ld_data[2:0]), .o_load_ready(ready8), .o_load_done(done8),
      .i_rd_en(rd), .i_pc(pc), .o_instr(instr8), .o_instr_valid(ival8),
      .o_pc_err(err8), .o_busy(busy8));

   instr_mem_prog #(.INSTR_W(4), .DEPTH(6)) dut6 (
      .i_clk(clk), .i_rst(rst), .i_load_start(start), .i_load_valid(lv),
      .i_load_data(ld_data), .o_load_ready(ready6), .o_load_done(done6),
      .i_rd_en(rd), .i_pc(pc), .o_instr(instr6), .o_instr_valid(ival6),
      .o_pc_err(err6), .o_busy(busy6));

   always #5 clk = ~clk;

   // Reference: program contents, load progress and expected outputs per instance.
   int dflt [8] = '{0, 7, 1, 2, 1, 3, 4, 6};
   int dep  [2] = '{8, 6};
   int msk  [2] = '{7, 15};
   int m_mem [2][8];
   int m_busy[2], m_ptr[2], m_instr[2], m_valid[2], m_err[2], m_done[2];

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         for (int a = 0; a < 8; a++) m_mem[k][a] = (a < dep[k]) ? dflt[a] : 0;
         m_busy[k] = 0; m_ptr[k] = 0; m_instr[k] = 0;
         m_valid[k] = 0; m_err[k] = 0; m_done[k] = 0;
      end
   endtask

   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         int d;
         d = int'(ld_data) & msk[k];
         m_valid[k] = 0; m_err[k] = 0; m_done[k] = 0;
         if (m_busy[k] == 0) begin
            if (start) begin
               m_busy[k] = 1; m_ptr[k] = 0;
            end else if (rd) begin
               m_valid[k] = 1;
               if (int'(pc) < dep[k]) m_instr[k] = m_mem[k][pc];
               else begin m_instr[k] = 0; m_err[k] = 1; end
            end
         end else if (lv && m_ptr[k] == dep[k] - 1) begin
            m_mem[k][m_ptr[k]] = d; m_ptr[k] = 0; m_done[k] = 1; m_busy[k] = 0;
         end else if (start) begin
            m_ptr[k] = 0;
            if (lv) begin m_mem[k][0] = d; m_ptr[k] = 1; end
         end else if (lv) begin
            m_mem[k][m_ptr[k]] = d; m_ptr[k]++;
         end
      end
   endtask

   task automatic check_all(input string tag);
      chk({tag, "/instr8"}, 32'(instr8), 32'(m_instr[0]));
      chk({tag, "/ival8"},  32'(ival8),  32'(m_valid[0]));
      chk({tag, "/err8"},   32'(err8),   32'(m_err[0]));
      chk({tag, "/done8"},  32'(done8),  32'(m_done[0]));
      chk({tag, "/busy8"},  32'(busy8),  32'(m_busy[0]));
      chk({tag, "/ready8"}, 32'(ready8), 32'(m_busy[0]));
      chk({tag, "/instr6"}, 32'(instr6), 32'(m_instr[1]));
      chk({tag, "/ival6"},  32'(ival6),  32'(m_valid[1]));
      chk({tag, "/err6"},   32'(err6),   32'(m_err[1]));
      chk({tag, "/done6"},  32'(done6),  32'(m_done[1]));
      chk({tag, "/busy6"},  32'(busy6),  32'(m_busy[1]));
      chk({tag, "/ready6"}, 32'(ready6), 32'(m_busy[1]));
   endtask

   task automatic cycle(input string tag);
      @(posedge clk);
      model_step();
      #1;
      check_all(tag);
   endtask

   task automatic drive(input logic s, input logic v, input logic [3:0] dat,
                        input logic r, input logic [2:0] p);
      start = s; lv = v; ld_data = dat; rd = r; pc = p;
   endtask

   task automatic do_reset(input string tag);
      rst = 1'b1;
      #1;
      model_reset();
      check_all(tag);
      @(posedge clk);
      #1;
      rst = 1'b0;
      drive(0, 0, 0, 0, 0);
   endtask

   initial begin
      model_reset();
      @(posedge clk); #1;
      do_reset("reset");

      // Default program read back-to-back, plus explicit constant image checks.
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 0, 1, 3'(i));
         cycle("dflt_rd");
         chk("dflt_word8", 32'(instr8), 32'(dflt[i]));
         chk("dflt_valid8", 32'(ival8), 32'd1);
      end
      chk("pc7_err6", 32'(err6), 32'd1);
      chk("pc7_instr6", 32'(instr6), 32'd0);
      drive(0, 0, 0, 1, 3'd5);
      cycle("pc5_6");
      chk("pc5_instr6", 32'(instr6), 32'b0011);
      chk("pc5_err6", 32'(err6), 32'd0);

      // Load 7..0 with a two-cycle gap after the fourth word.
      drive(1, 0, 0, 0, 0);
      cycle("ld_start");
      for (int i = 0; i < 8; i++) begin
         if (i == 4) begin
            drive(0, 0, 0, 0, 0);
            cycle("ld_gap"); cycle("ld_gap");
         end
         drive(0, 1, 4'(7 - i), 0, 0);
         cycle("ld_beat");
      end
      chk("ld_done8", 32'(done8), 32'd1);
      drive(0, 0, 0, 1, 3'd5);
      cycle("ld_rd5");
      chk("ld_rd5_8", 32'(instr8), 32'd2);

      // Reset in the middle of a load.
      drive(1, 0, 0, 0, 0);
      cycle("mid_start");
      for (int i = 0; i < 4; i++) begin
         drive(0, 1, 4'(i), 0, 0);
         cycle("mid_beat");
      end
      drive(0, 0, 0, 0, 0);
      do_reset("mid_rst");
      chk("mid_busy8", 32'(busy8), 32'd0);
      drive(0, 0, 0, 1, 3'd1);
      cycle("mid_rd1");
      chk("mid_rd1_8", 32'(instr8), 32'd7);

      // Restart after three beats, then eight beats of 5.
      drive(1, 0, 0, 0, 0);
      cycle("rs_start");
      for (int i = 0; i < 3; i++) begin
         drive(0, 1, 4'(i + 1), 0, 0);
         cycle("rs_pre");
      end
      drive(1, 0, 0, 0, 0);
      cycle("rs_restart");
      for (int i = 0; i < 8; i++) begin
         drive(0, 1, 4'd5, 0, 0);
         cycle("rs_beat");
         if (i < 7) chk("rs_nodone8", 32'(done8), 32'd0);
      end
      chk("rs_done8", 32'(done8), 32'd1);
      for (int i = 0; i < 8; i++) begin
         drive(0, 0, 0, 1, 3'(i));
         cycle("rs_rd");
         chk("rs_all5", 32'(instr8), 32'd5);
      end

      // Read and start together: read dropped, load begins.
      drive(1, 0, 0, 1, 3'd2);
      cycle("rd_start");
      chk("rs_ival8", 32'(ival8), 32'd0);
      chk("rs_busy8", 32'(busy8), 32'd1);
      chk("rs_hold8", 32'(instr8), 32'd5);
      drive(0, 0, 0, 0, 0);

      // Randomized traffic with occasional resets.
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 399) == 0) begin
            do_reset("rnd_rst");
         end else begin
            drive(($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 6),
                  4'($urandom), ($urandom_range(0, 9) < 7), 3'($urandom));
            cycle("rnd");
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_mem_prog.md
# instr_mem_prog

Parametrised instruction store for the bit-serial core, replacing the fixed 8×3 reset-loaded ROM. Holds DEPTH instructions of INSTR_W bits. Powers up with the built-in default program. Can be reprogrammed at run time through a valid/ready load port. The sequencer reads it through a registered, enable-qualified port with one-cycle latency.

## Interface
- INSTR_W, 3, instruction width in bits (≥3)
- DEPTH, 8, number of instruction entries (≥2, need not be a power of two)
- ADDR_W, $clog2(DEPTH), program-counter width (derived, not overridden)

- i_clk  input  1  clock, all state on rising edge
- i_rst  input  1  reset, asynchronous, active-high
- i_load_start  input  1  begin (or restart) a program load
- i_load_valid  input  1  i_load_data holds a word to write
- i_load_data  input  INSTR_W  instruction word to write
- o_load_ready  output  1  block accepts a load word this cycle
- o_load_done  output  1  one-cycle pulse: last word of a load written
- i_rd_en  input  1  read request
- i_pc  input  ADDR_W  read address
- o_instr  output  INSTR_W  registered read data
- o_instr_valid  output  1  o_instr updated by a read this cycle
- o_pc_err  output  1  accepted read had i_pc ≥ DEPTH
- o_busy  output  1  load in progress (state LOAD)

## Operation
- Storage is a flop array (DEPTH × INSTR_W) with asynchronous reset to the default program.
  - Entries 0..7: 000, 111, 001 (stall), 010 (mult y,d), 001 (stall), 011 (mult x,1-d), 100 (add y,x), 110 (wait switch off).
  - Each default word is zero-extended to INSTR_W. If DEPTH < 8, it is truncated to the first DEPTH entries.
  - Entries ≥ 8 reset to 0.
- FSM has two states: RUN and LOAD. Reset state is RUN.
- RUN:
  - i_load_start → LOAD; load pointer ← 0. The start takes priority over a same-cycle read: the read is dropped and o_instr_valid stays 0 next cycle.
  - i_rd_en with i_pc < DEPTH → next cycle o_instr = mem[i_pc], o_instr_valid = 1, o_pc_err = 0.
  - i_rd_en with i_pc ≥ DEPTH → next cycle o_instr = 0, o_instr_valid = 1, o_pc_err = 1.
  - No read → o_instr holds its value; o_instr_valid = 0 and o_pc_err = 0 next cycle.
- LOAD:
  - o_load_ready = 1 and o_busy = 1.
  - A word is accepted when i_load_valid && o_load_ready: mem[ptr] ← i_load_data and ptr ← ptr + 1.
  - When the accepted word is at ptr = DEPTH−1: ptr wraps to 0, o_load_done pulses for 1 cycle, state → RUN.
  - i_load_start in LOAD restarts at ptr 0. Words already written stay written. A word with i_load_valid in the same cycle is written at address 0.
  - i_rd_en in LOAD is ignored: o_instr holds, o_instr_valid = 0.
- i_load_start in the same cycle as the final load word: the word is written, the start is ignored, and the block returns to RUN.

## Timing
- Reset values: o_instr = 0, o_instr_valid = 0, o_pc_err = 0, o_load_ready = 0, o_load_done = 0, o_busy = 0, ptr = 0, FSM = RUN, memory = default program.
- Reset asserted mid-load aborts the load. Memory reverts to the default program, including words already loaded.
- Read latency is 1 cycle, with no bubbles; back-to-back reads give one result per cycle.
- o_load_ready and o_busy are registered and rise the cycle after i_load_start.
- A full load takes DEPTH accepted beats. The sender may insert gaps by deasserting i_load_valid.
- o_load_done is registered and asserts the cycle after the final beat, the same cycle o_busy falls.
- The earliest read of new contents is requested the cycle o_load_done is high; its data appears 1 cycle later.

## Test plan
- Reset, then read pc 0..7 back-to-back → o_instr = 000,111,001,010,001,011,100,110 on consecutive cycles, each 1 cycle after its request, o_instr_valid = 1 throughout.
- Start, load 8 words 7,6,5,4,3,2,1,0 with a 2-cycle valid gap after word 3 → o_load_done pulses once after the 8th beat; reading pc 5 returns 2.
- Reset asserted after 4 of 8 load words → o_busy = 0 immediately; reading pc 1 returns 111.
- Second i_load_start after 3 beats, then 8 beats of 5 → o_load_done pulses only after the 8th post-restart beat; all entries read 5.
- DEPTH = 6, INSTR_W = 4: read pc 6 → o_instr = 0, o_pc_err = 1 for one cycle; read pc 5 → 0011, o_pc_err = 0.
- i_rd_en and i_load_start in the same RUN cycle → o_instr_valid = 0 next cycle, o_busy = 1, o_instr unchanged.
